// File: rtl/neosd_cmd_engine.sv
// SD-card CMD line engine: sends a 48-bit command frame, optionally
// receives a 48/136-bit response, checks CRC7 and end bit, then idles.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   clk_en_i            SD bit strobe (one clk_i pulse per SD clock)
//   start_i             command request (accepted only when idle)
//   idx_i, arg_i        command index and argument
//   rmode_i             0 none, 1 short, 2 long, 3 short without CRC check
//   abort_i             abandon the current transaction
//   busy_o, done_o      transaction in progress / one-cycle completion pulse
//   timeout_o           no response start bit seen
//   crc_err_o           response CRC7 mismatch
//   end_err_o           response end bit was 0
//   resp_o              received frame, right-aligned
//   sd_cmd_o, sd_cmd_oe CMD line output and output enable
//   sd_cmd_i            CMD line input

module neosd_cmd_engine #(
    parameter int NCR_MAX   = 64,
    parameter int NCC_MIN   = 8,
    parameter bit CRC_CHECK = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clk_en_i,
    input  logic         start_i,
    input  logic [5:0]   idx_i,
    input  logic [31:0]  arg_i,
    input  logic [1:0]   rmode_i,
    input  logic         abort_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         timeout_o,
    output logic         crc_err_o,
    output logic         end_err_o,
    output logic [135:0] resp_o,
    output logic         sd_cmd_o,
    output logic         sd_cmd_oe,
    input  logic         sd_cmd_i
);

    localparam int M0 = (NCR_MAX > 136) ? NCR_MAX : 136;
    localparam int MX = (NCC_MIN > M0) ? NCC_MIN : M0;
    localparam int CW = $clog2(MX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_RX,
        S_GAP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [47:0]     tx_sr;
    logic [1:0]      rmode_q;
    logic [6:0]      crc_rx;

    logic [47:0]     tx_frame;
    logic [CW-1:0]   rx_last;
    logic            crc_en;
    logic            crc_chk;

    // Serial CRC7 step, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(
        input logic [6:0] c,
        input logic       b
    );
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        return c;
    endfunction

    always_comb begin
        tx_frame = {2'b01, idx_i, arg_i,
                    crc7_40({2'b01, idx_i, arg_i}), 1'b1};
    end

    // cnt holds the receive index of the bit currently on the line.
    // Short frames are checked from the start bit (index 0..39); long
    // frames skip the 8-bit header and stop before the CRC field.
    always_comb begin
        rx_last = (rmode_q == 2'd2) ? CW'(135) : CW'(47);
        if (rmode_q == 2'd2) begin
            crc_en = (cnt >= CW'(8)) && (cnt < CW'(128));
        end else begin
            crc_en = cnt < CW'(40);
        end
        crc_chk = CRC_CHECK &&
                  ((rmode_q == 2'd1) || (rmode_q == 2'd2));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tx_sr     <= '0;
            rmode_q   <= '0;
            crc_rx    <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            crc_err_o <= 1'b0;
            end_err_o <= 1'b0;
            resp_o    <= '0;
            sd_cmd_o  <= 1'b1;
            sd_cmd_oe <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (abort_i) begin
                state     <= S_IDLE;
                cnt       <= '0;
                busy_o    <= 1'b0;
                sd_cmd_o  <= 1'b1;
                sd_cmd_oe <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            tx_sr     <= tx_frame;
                            rmode_q   <= rmode_i;
                            timeout_o <= 1'b0;
                            crc_err_o <= 1'b0;
                            end_err_o <= 1'b0;
                            busy_o    <= 1'b1;
                            cnt       <= '0;
                            state     <= S_TX;
                        end
                    end
                    S_TX: begin
                        if (clk_en_i) begin
                            // The strobe after the end bit releases the line.
                            if (cnt == CW'(48)) begin
                                sd_cmd_oe <= 1'b0;
                                sd_cmd_o  <= 1'b1;
                                cnt       <= '0;
                                state     <= (rmode_q == 2'd0) ?
                                             S_GAP : S_WAIT;
                            end else begin
                                sd_cmd_o  <= tx_sr[47];
                                sd_cmd_oe <= 1'b1;
                                tx_sr     <= {tx_sr[46:0], 1'b0};
                                cnt       <= cnt + 1'b1;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (clk_en_i) begin
                            if (!sd_cmd_i) begin
                                resp_o <= '0;
                                crc_rx <= '0;
                                cnt    <= CW'(1);
                                state  <= S_RX;
                            end else if (cnt == CW'(NCR_MAX - 1)) begin
                                timeout_o <= 1'b1;
                                cnt       <= '0;
                                state     <= S_GAP;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    S_RX: begin
                        if (clk_en_i) begin
                            resp_o <= {resp_o[134:0], sd_cmd_i};
                            if (crc_en) begin
                                crc_rx <= crc7_step(crc_rx, sd_cmd_i);
                            end
                            // On the end bit, resp_o[6:0] still holds
                            // frame bits [7:1], the received CRC field.
                            if (cnt == rx_last) begin
                                end_err_o <= ~sd_cmd_i;
                                crc_err_o <= crc_chk &&
                                             (crc_rx != resp_o[6:0]);
                                cnt       <= '0;
                                state     <= S_GAP;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    S_GAP: begin
                        if (clk_en_i) begin
                            if (cnt == CW'(NCC_MIN - 1)) begin
                                cnt    <= '0;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                                state  <= S_IDLE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/neosd_cmd_engine.md
NEOSD_CMD_ENGINE -- requirements
Module: neosd_cmd_engine

Interface
REQ-001 SHALL have parameter NCR_MAX, default 64: number of SD-clock strobes to wait for a response start bit before timeout.
REQ-002 SHALL have parameter NCC_MIN, default 8: idle strobes after each transaction before a new command is accepted.
REQ-003 SHALL have parameter CRC_CHECK, default 1: 0 disables response CRC checking for all modes.
REQ-004 SHALL have one clock and one reset, exactly as follows: clk_i  in  1  single clock; rst_i  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port clk_en_i  in  1  SD bit strobe: one clk_i-cycle pulse per SD clock period.
REQ-006 SHALL have port start_i  in  1  command request, sampled on any clk_i cycle.
REQ-007 SHALL have port idx_i  in  6  command index.
REQ-008 SHALL have port arg_i  in  32  command argument.
REQ-009 SHALL have port rmode_i  in  2  response mode: 0 none, 1 short (48 b), 2 long (136 b), 3 short without CRC check.
REQ-010 SHALL have port abort_i  in  1  abort the current transaction.
REQ-011 SHALL have ports busy_o out 1, done_o out 1 (single-cycle pulse), timeout_o out 1, crc_err_o out 1, end_err_o out 1.
REQ-012 SHALL have port resp_o  out  136  received frame, right-aligned; a short frame occupies [47:0] and [135:48] is zero.
REQ-013 SHALL have ports sd_cmd_o out 1, sd_cmd_oe out 1, sd_cmd_i in 1.

Function
REQ-014 SHALL implement states IDLE, TX, WAIT, RX and GAP; every state advance other than start acceptance and abort occurs only on clk_en_i.
REQ-015 SHALL accept start_i only in IDLE; on acceptance it latches idx_i, arg_i and rmode_i, clears all flags, and asserts busy_o on the next clk_i cycle.
REQ-016 SHALL, in TX, send 48 bits MSB first: 0, 1, idx[5:0], arg[31:0], CRC7[6:0], 1.
REQ-017 SHALL compute CRC7 internally with polynomial x^7+x^3+1, initial value 0, over the first 40 frame bits.
REQ-018 SHALL update sd_cmd_o and assert sd_cmd_oe on the first strobe after acceptance, change one bit per strobe, and deassert sd_cmd_oe on the strobe after the end bit.
REQ-019 SHALL drive sd_cmd_o to 1 whenever sd_cmd_oe is 0.
REQ-020 SHALL, after TX, go to GAP when rmode is 0, otherwise to WAIT.
REQ-021 SHALL, in WAIT, sample sd_cmd_i on each strobe; the first 0 moves the engine to RX with that bit stored as frame bit 0.
REQ-022 SHALL, in WAIT, set timeout_o and go to GAP after NCR_MAX strobes without a 0.
REQ-023 SHALL, in RX, shift sd_cmd_i into resp_o LSB-first-in, one bit per strobe, until 48 bits (short) or 136 bits (long) in total are received.
REQ-024 SHALL check the short-response CRC7 over frame bits [47:8] against [7:1].
REQ-025 SHALL check the long-response CRC7 over frame bits [127:8] against [7:1].
REQ-026 SHALL set crc_err_o on CRC mismatch, except when rmode is 3 or CRC_CHECK is 0.
REQ-027 SHALL set end_err_o when frame bit [0] is 0.
REQ-028 SHALL, in GAP, count NCC_MIN strobes and then enter IDLE, deassert busy_o, and pulse done_o for one clk_i cycle.
REQ-029 SHALL hold timeout_o, crc_err_o, end_err_o and resp_o from done_o until the next accepted start; timeout leaves resp_o unchanged.
REQ-030 SHALL, on abort_i in any state, enter IDLE on the next clk_i cycle with sd_cmd_oe=0, busy_o=0 and no done_o pulse.
REQ-031 SHALL give abort_i priority over start_i when both are asserted; start_i while busy_o=1 SHALL be ignored.

Reset
REQ-032 SHALL, while rst_i=1, asynchronously force IDLE, sd_cmd_o=1, sd_cmd_oe=0, busy_o=0, done_o=0, all flags 0, resp_o=0, and all counters 0, including when reset occurs mid-transaction.

Verification
REQ-033 SHALL be verified with: idx=0, arg=0, rmode=0 -> sd_cmd_o carries 0x400000000095 over 48 strobes with oe high, done_o after 8 GAP strobes, flags 0.
REQ-034 SHALL be verified with: idx=8, arg=0x000001AA, rmode=1 -> frame 0x48000001AA87; a model R7 with valid CRC gives resp_o[47:0]=frame and flags 0; the same R7 with one CRC bit flipped gives crc_err_o=1.
REQ-035 SHALL be verified with: rmode=1 and sd_cmd_i held at 1 -> timeout_o=1 after exactly 64 WAIT strobes, resp_o unchanged.
REQ-036 SHALL be verified with: rmode=2 and a model 136-bit R2 with valid CRC over [127:8] -> resp_o equals the frame; the same R2 with end bit 0 gives end_err_o=1.
REQ-037 SHALL be verified with: abort_i at TX bit 20 -> oe=0 and busy_o=0 on the next clk_i, no done_o; an immediate new start sends a complete frame.
REQ-038 SHALL be verified with: rst_i pulsed mid-RX -> every output at its reset value in the same cycle, and a subsequent command completes normally.
